// File: rtl/dmem_lsu_pkg.sv
// Shared types and helpers for the data-memory load/store unit.
// Size encodings, FSM states and lane/strobe/alignment helpers.
package dmem_lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_B   = 2'b00,
        SIZE_H   = 2'b01,
        SIZE_W   = 2'b10,
        SIZE_RSV = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUS  = 2'b01,
        S_RESP = 2'b10
    } state_e;

    // Load formatting context kept for the duration of a transfer
    typedef struct packed {
        size_e      size;
        logic       sgn;
        logic [1:0] off;
    } ld_ctx_t;

    function automatic logic is_aligned(
        input size_e      s,
        input logic [1:0] off
    );
        logic ok;
        ok = 1'b0;
        case (s)
            SIZE_B:  ok = 1'b1;
            SIZE_H:  ok = ~off[0];
            SIZE_W:  ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] strb_of(
        input size_e      s,
        input logic [1:0] off
    );
        logic [3:0] st;
        st = 4'b1111;
        case (s)
            SIZE_B:  st = 4'b0001 << off;
            SIZE_H:  st = 4'b0011 << {off[1], 1'b0};
            default: st = 4'b1111;
        endcase
        return st;
    endfunction

    function automatic logic [31:0] wdata_of(
        input size_e       s,
        input logic [31:0] d
    );
        logic [31:0] w;
        w = d;
        case (s)
            SIZE_B:  w = {4{d[7:0]}};
            SIZE_H:  w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Core request / data bus bundle for the load/store unit.
// master = core + memory side, slave = the load/store unit.
interface dmem_lsu_if;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        misaligned;
    logic        bus_err;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_we, req_size, req_signed,
        output req_addr, req_wdata, mem_ready, mem_rdata,
        input  stall, rdata, rdata_valid, misaligned,
        input  bus_err, mem_valid, mem_we, mem_addr,
        input  mem_wstrb, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed,
        input  req_addr, req_wdata, mem_ready, mem_rdata,
        output stall, rdata, rdata_valid, misaligned,
        output bus_err, mem_valid, mem_we, mem_addr,
        output mem_wstrb, mem_wdata
    );
endinterface

// File: rtl/dmem_load_format.sv
// Load data formatter: picks the addressed lane out of the bus
// word and sign/zero-extends byte and half loads to 32 bits.
module dmem_load_format
    import dmem_lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  size_e       size_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);

    logic [31:0] lane;

    // Lane select then extension by access size
    always_comb begin
        lane   = word_i >> {off_i, 3'b000};
        data_o = word_i;
        case (size_i)
            SIZE_B: data_o = {{24{signed_i & lane[7]}},
                              lane[7:0]};
            SIZE_H: data_o = {{16{signed_i & lane[15]}},
                              lane[15:0]};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: aligns core accesses onto a word
// bus with strobes, stalls until ack/timeout, returns load data.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic       clk,
    input logic       rst,
    dmem_lsu_if.slave bus
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);

    state_e      state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    ld_ctx_t     ctx_q;
    logic        mem_valid_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_wstrb_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] rdata_q;
    logic        rdata_valid_q;
    logic        misaligned_q;
    logic        bus_err_q;

    size_e       req_size;
    logic        aligned;
    logic        expire;
    logic [31:0] load_data;

    assign req_size = size_e'(bus.req_size);
    assign aligned  = is_aligned(req_size, bus.req_addr[1:0]);
    assign cnt_d    = cnt_q + 1'b1;
    assign expire   = (TIMEOUT_CYCLES != 0) &&
                      (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    dmem_load_format u_fmt (
        .word_i   (bus.mem_rdata),
        .off_i    (ctx_q.off),
        .size_i   (ctx_q.size),
        .signed_i (ctx_q.sgn),
        .data_o   (load_data)
    );

    // Transfer FSM with timeout counter and registered bus outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            ctx_q         <= '0;
            mem_valid_q   <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wstrb_q   <= '0;
            mem_wdata_q   <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            rdata_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
            bus_err_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (bus.req_valid && aligned) begin
                        ctx_q.size  <= req_size;
                        ctx_q.sgn   <= bus.req_signed;
                        ctx_q.off   <= bus.req_addr[1:0];
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= bus.req_we;
                        mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
                        mem_wstrb_q <= bus.req_we ?
                            strb_of(req_size, bus.req_addr[1:0]) :
                            4'b0000;
                        mem_wdata_q <= wdata_of(req_size,
                                                bus.req_wdata);
                        state_q     <= S_BUS;
                    end else if (bus.req_valid) begin
                        misaligned_q <= 1'b1;
                        rdata_q      <= '0;
                    end
                end
                S_BUS: begin
                    cnt_q <= cnt_d;
                    if (bus.mem_ready) begin
                        mem_valid_q   <= 1'b0;
                        rdata_valid_q <= 1'b1;
                        if (!mem_we_q) begin
                            rdata_q <= load_data;
                        end
                        state_q <= S_RESP;
                    end else if (expire) begin
                        mem_valid_q   <= 1'b0;
                        rdata_valid_q <= 1'b1;
                        bus_err_q     <= 1'b1;
                        rdata_q       <= '0;
                        state_q       <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.stall = ((state_q == S_IDLE) &&
                        bus.req_valid && aligned) ||
                       (state_q == S_BUS);

    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.misaligned  = misaligned_q;
    assign bus.bus_err     = bus_err_q;
    assign bus.mem_valid   = mem_valid_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wstrb   = mem_wstrb_q;
    assign bus.mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a short bus timeout.
// Hand-computed vectors for loads, stores, errors and reset.
module tb_dmem_lsu;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dmem_lsu_if bus ();

    dmem_lsu #(
        .TIMEOUT_CYCLES (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    int          stalls;
    int          resp_i;
    logic        snap_valid;
    logic        snap_we;
    logic [31:0] snap_addr;
    logic [3:0]  snap_strb;
    logic [31:0] snap_wdata;
    logic [31:0] got_rdata;
    logic        got_err;
    logic        got_mv;
    logic        end_rv;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic        we,
                       input logic [1:0]  sz,
                       input logic        sg,
                       input logic [31:0] addr,
                       input logic [31:0] wd,
                       input logic [31:0] rd,
                       input int          wait_n);
        stalls     = 0;
        resp_i     = -1;
        snap_valid = 1'b0;
        got_rdata  = 'x;
        got_err    = 1'bx;
        got_mv     = 1'bx;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        for (int i = 0; i < 12; i++) begin
            bus.mem_ready = (i != 0) && (i == wait_n);
            bus.mem_rdata = rd;
            #1;
            if (i == 1) begin
                snap_valid = bus.mem_valid;
                snap_we    = bus.mem_we;
                snap_addr  = bus.mem_addr;
                snap_strb  = bus.mem_wstrb;
                snap_wdata = bus.mem_wdata;
            end
            if (bus.stall) stalls++;
            if (bus.rdata_valid || bus.bus_err) begin
                resp_i    = i;
                got_rdata = bus.rdata;
                got_err   = bus.bus_err;
                got_mv    = bus.mem_valid;
                break;
            end
            tick();
        end
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        end_rv = bus.rdata_valid;
    endtask

    task automatic mis(input logic [1:0]  sz,
                       input logic [31:0] addr,
                       input string       tag);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_size   = sz;
        bus.req_signed = 1'b0;
        bus.req_addr   = addr;
        #1;
        chk({tag, " stall"}, 32'(bus.stall), 32'd0);
        tick();
        bus.req_valid = 1'b0;
        chk({tag, " pulse"}, 32'(bus.misaligned), 32'd1);
        chk({tag, " rdata"}, bus.rdata, 32'd0);
        chk({tag, " mvalid"}, 32'(bus.mem_valid), 32'd0);
        tick();
        chk({tag, " pulse end"}, 32'(bus.misaligned), 32'd0);
        chk({tag, " mvalid2"}, 32'(bus.mem_valid), 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = '0;
        tick();
        tick();
        chk("rst mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("rst mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst mem_addr", bus.mem_addr, 32'd0);
        chk("rst wstrb", 32'(bus.mem_wstrb), 32'd0);
        chk("rst wdata", bus.mem_wdata, 32'd0);
        chk("rst rdata", bus.rdata, 32'd0);
        chk("rst rvalid", 32'(bus.rdata_valid), 32'd0);
        chk("rst misal", 32'(bus.misaligned), 32'd0);
        chk("rst buserr", 32'(bus.bus_err), 32'd0);
        chk("rst stall", 32'(bus.stall), 32'd0);
        rst = 1'b0;
        tick();

        run(1'b0, 2'b10, 1'b0, 32'h100, 32'h0,
            32'hDEADBEEF, 2);
        chk("lw rdata", got_rdata, 32'hDEADBEEF);
        chk("lw stalls", stalls, 3);
        chk("lw resp cyc", resp_i, 3);
        chk("lw mv at resp", 32'(got_mv), 32'd0);
        chk("lw err", 32'(got_err), 32'd0);
        chk("lw bus valid", 32'(snap_valid), 32'd1);
        chk("lw bus addr", snap_addr, 32'h100);
        chk("lw bus strb", 32'(snap_strb), 32'h0);
        chk("lw bus we", 32'(snap_we), 32'd0);
        chk("lw pulse end", 32'(end_rv), 32'd0);

        run(1'b0, 2'b00, 1'b1, 32'h103, 32'h0,
            32'h80000000, 1);
        chk("lb rdata", got_rdata, 32'hFFFFFF80);
        chk("lb stalls", stalls, 2);
        chk("lb resp cyc", resp_i, 2);
        chk("lb bus addr", snap_addr, 32'h100);

        run(1'b0, 2'b00, 1'b0, 32'h103, 32'h0,
            32'h80000000, 1);
        chk("lbu rdata", got_rdata, 32'h00000080);

        run(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD,
            32'hFFFFFFFF, 1);
        chk("sh bus addr", snap_addr, 32'h200);
        chk("sh bus strb", 32'(snap_strb), 32'hC);
        chk("sh bus wdata", snap_wdata, 32'hABCDABCD);
        chk("sh bus we", 32'(snap_we), 32'd1);
        chk("sh rdata kept", got_rdata, 32'h00000080);

        run(1'b1, 2'b00, 1'b0, 32'h101, 32'h00000077,
            32'h0, 1);
        chk("sb bus strb", 32'(snap_strb), 32'h2);
        chk("sb bus wdata", snap_wdata, 32'h77777777);

        run(1'b1, 2'b10, 1'b0, 32'h300, 32'hCAFEF00D,
            32'h0, 1);
        chk("sw bus strb", 32'(snap_strb), 32'hF);
        chk("sw bus wdata", snap_wdata, 32'hCAFEF00D);

        run(1'b0, 2'b01, 1'b1, 32'h102, 32'h0,
            32'h80017FFF, 1);
        chk("lh rdata", got_rdata, 32'hFFFF8001);

        run(1'b0, 2'b01, 1'b0, 32'h000, 32'h0,
            32'h1234F00F, 1);
        chk("lhu rdata", got_rdata, 32'h0000F00F);

        run(1'b0, 2'b00, 1'b1, 32'h101, 32'h0,
            32'hFF007FFF, 1);
        chk("lb pos rdata", got_rdata, 32'h0000007F);

        run(1'b0, 2'b10, 1'b0, 32'h400, 32'h0,
            32'h11111111, 99);
        chk("tmo err", 32'(got_err), 32'd1);
        chk("tmo rdata", got_rdata, 32'd0);
        chk("tmo mv", 32'(got_mv), 32'd0);
        chk("tmo resp cyc", resp_i, 5);
        chk("tmo stalls", stalls, 5);

        run(1'b0, 2'b10, 1'b0, 32'h404, 32'h0,
            32'h13579BDF, 4);
        chk("edge rdata", got_rdata, 32'h13579BDF);
        chk("edge err", 32'(got_err), 32'd0);
        chk("edge stalls", stalls, 5);

        mis(2'b10, 32'h102, "mis lw");
        mis(2'b01, 32'h101, "mis lh");
        mis(2'b11, 32'h100, "mis rsv");

        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b10;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h500;
        tick();
        chk("rstbus mv", 32'(bus.mem_valid), 32'd1);
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        tick();
        chk("rstbus mv0", 32'(bus.mem_valid), 32'd0);
        chk("rstbus rv0", 32'(bus.rdata_valid), 32'd0);
        chk("rstbus stall", 32'(bus.stall), 32'd0);
        rst = 1'b0;
        tick();
        chk("rstbus rv1", 32'(bus.rdata_valid), 32'd0);
        chk("rstbus mv1", 32'(bus.mem_valid), 32'd0);
        tick();
        chk("rstbus rv2", 32'(bus.rdata_valid), 32'd0);

        run(1'b0, 2'b10, 1'b0, 32'h600, 32'h0,
            32'h2468ACE0, 1);
        chk("post rst rdata", got_rdata, 32'h2468ACE0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
